// File: rtl/ddfs_pkg.sv
// ddfs_pkg: shared types and constant generators for the multi-channel
// CORDIC direct digital frequency synthesizer.
//   ddfs_state_e : sweep FSM states
//   ch_w()       : channel index width (at least 1 bit)
//   k_fix()      : CORDIC gain compensation round(0.607252935 * 2^frac)
//   atan_turn()  : atan(2^-i) expressed in turns scaled by 2^pw
// All helpers are constant functions evaluated at elaboration time.
package ddfs_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, ROTATE, OUT} ddfs_state_e;

   // Fixed-point scale used while building the arctangent table.
   localparam int ATAN_SC = 96;

   function automatic int ch_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic logic [127:0] k_fix(input int frac);
      logic [127:0] num;
      num = 128'd607252935 << frac;
      return (num + 128'd500000000) / 128'd1000000000;
   endfunction

   // atan(1/n) * 2^ATAN_SC by the alternating Taylor series; partial sums
   // never go negative, so unsigned arithmetic is safe.
   function automatic logic [191:0] atan_inv(input logic [191:0] n);
      logic [191:0] p, sum;
      p   = (192'd1 << ATAN_SC) / n;
      sum = '0;
      for (int k = 0; k < 100; k++) begin
         if (k % 2 == 1) sum = sum - p / 192'(2 * k + 1);
         else            sum = sum + p / 192'(2 * k + 1);
         p = p / (n * n);
      end
      return sum;
   endfunction

   // One turn = 2*pi = 8 * (pi/4); pi/4 comes from Machin's formula so the
   // table needs no real arithmetic.
   function automatic logic [127:0] atan_turn(input int i, input int pw);
      logic [191:0] a, pi4, den;
      if (i == 0) return 128'd1 << (pw - 3);
      a   = atan_inv(192'd1 << i);
      pi4 = 192'd4 * atan_inv(192'd5) - atan_inv(192'd239);
      den = pi4 << 3;
      return 128'(((a << pw) + (den >> 1)) / den);
   endfunction

endpackage

// File: rtl/cordic_iter_core.sv
// cordic_iter_core: iterative rotation-mode CORDIC, one micro-rotation per
// clock. start loads x = K_FIX, y = 0, z = z_in; the following ITER cycles
// each perform one rotation. done is asserted combinationally during the
// last rotation cycle, together with x_res/y_res, which already carry the
// result of that final rotation (guard bits dropped).
//   clk, reset   : clock, synchronous active-high reset
//   start        : load a new angle (turn units, signed, |z| <= 1/4 turn)
//   z_in         : angle to rotate by
//   done         : final rotation in progress, results valid
//   x_res, y_res : cos / sin of z_in, Q(WIDTH-FRAC-1).FRAC
module cordic_iter_core
   import ddfs_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FRAC    = 28,
   parameter int PHASE_W = 32,
   parameter int ITER    = 24
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [PHASE_W-1:0]        z_in,
   output logic                      done,
   output logic signed [WIDTH-1:0]   x_res,
   output logic signed [WIDTH-1:0]   y_res
);

   // Two extra LSBs limit truncation noise from the repeated shifts.
   localparam int XW = WIDTH + 2;
   localparam int CW = $clog2(ITER);
   localparam logic [127:0] KW = k_fix(FRAC);
   localparam logic signed [XW-1:0] XK = {KW[WIDTH-1:0], 2'b00};

   logic [ITER-1:0][PHASE_W-1:0] atan_rom;

   for (genvar i = 0; i < ITER; i++) begin : g_atan
      localparam logic [127:0] AW = atan_turn(i, PHASE_W);
      assign atan_rom[i] = AW[PHASE_W-1:0];
   end

   logic signed [XW-1:0]      x_q, y_q, x_d, y_d, xs, ys;
   logic signed [PHASE_W-1:0] z_q, z_d;
   logic [CW-1:0]             cnt_q;
   logic                      run_q;
   logic                      unused_guard;

   always_comb begin
      xs  = x_q >>> cnt_q;
      ys  = y_q >>> cnt_q;
      x_d = x_q;
      y_d = y_q;
      z_d = z_q;
      if (!z_q[PHASE_W-1]) begin
         x_d = x_q - ys;
         y_d = y_q + xs;
         z_d = z_q - $signed(atan_rom[cnt_q]);
      end else begin
         x_d = x_q + ys;
         y_d = y_q - xs;
         z_d = z_q + $signed(atan_rom[cnt_q]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         z_q   <= '0;
      end else if (start) begin
         run_q <= 1'b1;
         cnt_q <= '0;
         x_q   <= XK;
         y_q   <= '0;
         z_q   <= z_in;
      end else if (run_q) begin
         x_q   <= x_d;
         y_q   <= y_d;
         z_q   <= z_d;
         cnt_q <= cnt_q + 1'b1;
         if (done) run_q <= 1'b0;
      end
   end

   assign done  = run_q && (cnt_q == CW'(ITER - 1));
   assign x_res = x_d[XW-1:2];
   assign y_res = y_d[XW-1:2];

   assign unused_guard = ^{x_d[1:0], y_d[1:0]};

endmodule

// File: rtl/ddfs_cordic_nch.sv
// ddfs_cordic_nch: NCH-channel DDFS sharing one iterative CORDIC. Each en
// tick sweeps channels 0..NCH-1; every channel takes ITER+2 cycles
// (LOAD, ITER x ROTATE, OUT) and emits one sin/cos sample.
//   clk, reset        : clock, synchronous active-high reset
//   en                : sample tick, starts a sweep (dropped while busy)
//   phase_sync        : only with DDFS_PHASE_SYNC_EN defined; clears all
//                       accumulators when seen in IDLE
//   cfg_we/ch/ftw/poff: per-channel tuning word and phase offset write
//   sin_o, cos_o, ch_o: sample and its channel, held between strobes
//   valid_o           : one-cycle sample strobe
//   busy_o            : sweep in progress
//   overrun_o         : sticky, en arrived while busy
// Optional feature macro: DDFS_PHASE_SYNC_EN.
module ddfs_cordic_nch
   import ddfs_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FRAC    = 28,
   parameter int PHASE_W = 32,
   parameter int ITER    = 24,
   parameter int NCH     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
`ifdef DDFS_PHASE_SYNC_EN
   input  logic                      phase_sync,
`endif
   input  logic                      cfg_we,
   input  logic [ch_w(NCH)-1:0]      cfg_ch,
   input  logic [PHASE_W-1:0]        cfg_ftw,
   input  logic [PHASE_W-1:0]        cfg_poff,
   output logic signed [WIDTH-1:0]   sin_o,
   output logic signed [WIDTH-1:0]   cos_o,
   output logic [ch_w(NCH)-1:0]      ch_o,
   output logic                      valid_o,
   output logic                      busy_o,
   output logic                      overrun_o
);

   localparam int CHW = ch_w(NCH);

   ddfs_state_e state_q, state_d;

   logic [NCH-1:0][PHASE_W-1:0] acc_q, ftw_q, poff_q;
   logic [CHW-1:0]              ch_q;
   logic                        neg_q;
   logic                        last_ch, cfg_ok, fold;
   logic [PHASE_W-1:0]          phase, z_load;
   logic                        core_done;
   logic signed [WIDTH-1:0]     x_res, y_res;

   assign last_ch = (32'(ch_q) == NCH - 1);
   assign cfg_ok  = (32'(cfg_ch) < NCH);
   assign busy_o  = (state_q != IDLE);

   // Quadrants 2 and 3 are rotated by a half turn into CORDIC range and the
   // result negated afterwards.
   assign phase  = acc_q[ch_q] + poff_q[ch_q];
   assign fold   = phase[PHASE_W-1] ^ phase[PHASE_W-2];
   assign z_load = fold ? {~phase[PHASE_W-1], phase[PHASE_W-2:0]} : phase;

   cordic_iter_core #(
      .WIDTH   (WIDTH),
      .FRAC    (FRAC),
      .PHASE_W (PHASE_W),
      .ITER    (ITER)
   ) u_core (
      .clk   (clk),
      .reset (reset),
      .start (state_q == LOAD),
      .z_in  (z_load),
      .done  (core_done),
      .x_res (x_res),
      .y_res (y_res)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = LOAD;
         LOAD:    state_d = ROTATE;
         ROTATE:  if (core_done) state_d = OUT;
         OUT:     state_d = last_ch ? IDLE : LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q     <= '0;
         ftw_q     <= '0;
         poff_q    <= '0;
         ch_q      <= '0;
         neg_q     <= 1'b0;
         sin_o     <= '0;
         cos_o     <= '0;
         ch_o      <= '0;
         valid_o   <= 1'b0;
         overrun_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (cfg_we && cfg_ok) begin
            ftw_q[cfg_ch]  <= cfg_ftw;
            poff_q[cfg_ch] <= cfg_poff;
         end
         if (en && state_q != IDLE) overrun_o <= 1'b1;
         case (state_q)
            IDLE:   if (en) ch_q <= '0;
            LOAD:   neg_q <= fold;
            ROTATE: if (core_done) begin
               // Register the final rotation so the strobe lands in OUT.
               valid_o <= 1'b1;
               ch_o    <= ch_q;
               cos_o   <= neg_q ? -x_res : x_res;
               sin_o   <= neg_q ? -y_res : y_res;
            end
            OUT: begin
               acc_q[ch_q] <= acc_q[ch_q] + ftw_q[ch_q];
               if (!last_ch) ch_q <= ch_q + 1'b1;
            end
            default: ;
         endcase
`ifdef DDFS_PHASE_SYNC_EN
         if (state_q == IDLE && phase_sync) acc_q <= '0;
`endif
      end
   end

endmodule
